instr_sequencer: RTL
====================

Name: instr_sequencer

Overview:
Parametrised, synthesisable instruction sequencer that replaces hand-timed instruction driving in front of the `org` RV32I datapath. It holds a small program memory, issues instructions over a valid/ready handshake, and holds each instruction stable for a programmable number of cycles. It captures the core's `result` per instruction and supports single-pass, loop and abort operation. It sits between a loader (bench or debug port) and the core's `instr`/`result` pins.

Parameters:
- XLEN, 32, instruction/result width
- DEPTH, 16, program memory entries (power of 2, ≥2); AW = $clog2(DEPTH)
- HOLD_CYCLES, 2, cycles an accepted instruction is held after handshake (≥1)
- NOP_INSTR, 32'h00000013, value driven when not issuing (addi x0,x0,0)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- load_we  in  1  program write strobe; ignored while busy
- load_addr  in  AW  program write address
- load_data  in  XLEN  program write data
- prog_len  in  AW+1  instruction count, 0..DEPTH; sampled on start
- loop_en  in  1  restart at index 0 after last instruction; sampled on start
- start  in  1  begin run (IDLE only)
- abort  in  1  terminate run
- instr  out  XLEN  instruction to core
- instr_valid  out  1  instr is offered
- instr_ready  in  1  core accepts instr
- result  in  XLEN  core result
- last_result  out  XLEN  result captured for most recent instruction
- pc_idx  out  AW  current program index
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse at end of non-loop run
- issued_cnt  out  16  handshakes since start, saturating at 16'hFFFF

Behaviour:
- Reset (reset=0, async):
  - State = IDLE.
  - instr = NOP_INSTR; instr_valid, busy and done = 0.
  - pc_idx = 0, issued_cnt = 0, last_result = 0.
  - Program memory is not cleared.
- States: IDLE, ISSUE, HOLD, DONE.
- IDLE:
  - start && prog_len ≠ 0: latch prog_len and loop_en, clear issued_cnt, pc_idx = 0, go to ISSUE next cycle.
  - start && prog_len == 0: go to DONE (done pulse, nothing issued).
  - prog_len > DEPTH is clamped to DEPTH.
- ISSUE:
  - instr = mem[pc_idx], instr_valid = 1. Start→first valid latency is 1 cycle.
  - Stay until instr_ready=1. The handshake cycle increments issued_cnt, loads the hold counter with HOLD_CYCLES, and moves to HOLD.
- HOLD:
  - instr_valid = 0; instr remains mem[pc_idx], stable.
  - Counter decrements each cycle. On the last HOLD cycle, last_result ← result.
  - Then:
    - If pc_idx < len−1: pc_idx+1, go to ISSUE.
    - Else, if loop_en: pc_idx = 0, go to ISSUE.
    - Else: go to DONE.
  - Per-instruction period = 1 + HOLD_CYCLES cycles with instr_ready tied high.
- DONE:
  - done = 1 for exactly one cycle, instr = NOP_INSTR, then IDLE.
- abort (highest priority, any non-IDLE state):
  - Next cycle IDLE, instr = NOP_INSTR, instr_valid = 0, no done pulse.
  - pc_idx, issued_cnt and last_result are retained.
- start while busy: ignored. load_we while busy: ignored, memory unchanged.
- Simultaneous start and abort in IDLE: abort wins, stay IDLE.
- issued_cnt saturates, never wraps. pc_idx wraps only via the loop rule.
- Memory read is asynchronous. A write in IDLE is visible on the next start.

Optional Feature:
- Macro: INSTR_SEQUENCER_CHECK_EN.
- Defined:
  - Adds ports `exp_we` (in, 1), `exp_data` (in, XLEN), `mismatch` (out, 1, sticky) and `err_idx` (out, AW).
  - Expected-result memory is written at load_addr.
  - At each result capture, if result ≠ exp[pc_idx]: set mismatch, and record err_idx on the first mismatch only.
  - Both are cleared on reset and on accepted start.
- Undefined: none of these ports or the expected memory exist; behaviour otherwise identical.

Decomposition:
- Package instr_seq_pkg: state enum (IDLE/ISSUE/HOLD/DONE), NOP_INSTR constant, RV32I opcode constants (OP_IMM 7'b0010011, OP 7'b0110011, STORE 7'b0100011).
- Sub-module seq_prog_mem: DEPTH×XLEN, one sync write port, one async read port. Instantiated once for the program, and a second time for expected results under the macro.

Test Plan:
- Load 0x00600093, 0x00700113, 0x402081B3 (prog_len=3, loop_en=0, ready=1, HOLD_CYCLES=2), pulse start → instr sequence with 3-cycle period, issued_cnt=3, done pulse 10 cycles after start, last_result=0xFFFFFFFF (6−7).
- Same program with instr_ready low for 4 cycles on index 1 → instr holds 0x00700113 with valid=1 throughout; issued_cnt unchanged until ready.
- prog_len=2, loop_en=1, abort at cycle 20 → pc_idx wraps 1→0, no done pulse, instr=0x00000013 and busy=0 the cycle after abort.
- prog_len=0 start → done pulse next cycle, instr_valid never 1; load_we during a run → memory unchanged.
- reset asserted mid-HOLD → all outputs reach reset values immediately (asynchronous); restart runs from index 0.
- INSTR_SEQUENCER_CHECK_EN: expected 6, 7, 0 against results 6, 7, 0xFFFFFFFF → mismatch=1, err_idx=2.

Source files
------------

// File: rtl/instr_seq_pkg.sv
// Shared types and constants for the instruction sequencer and its program memory.
package instr_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        HOLD,
        DONE
    } seq_state_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] STORE  = 7'b0100011;

endpackage

// File: rtl/seq_prog_mem.sv
// DEPTH x XLEN storage with one synchronous write port and one asynchronous read port.
module seq_prog_mem #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [XLEN-1:0]          wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [XLEN-1:0]          rdata
);

    logic [XLEN-1:0] mem [DEPTH];

    // Contents are deliberately left uninitialised across reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Issues a stored program to the core over valid/ready, holding each instruction for HOLD_CYCLES.
// Optional result checking against an expected-result memory: define INSTR_SEQUENCER_CHECK_EN.
module instr_sequencer #(
    parameter int              XLEN        = 32,
    parameter int              DEPTH       = 16,
    parameter int              HOLD_CYCLES = 2,
    parameter logic [XLEN-1:0] NOP_INSTR   = XLEN'(instr_seq_pkg::NOP_INSTR)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_we,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [XLEN-1:0]          load_data,
    input  logic [$clog2(DEPTH):0]   prog_len,
    input  logic                     loop_en,
    input  logic                     start,
    input  logic                     abort,
    output logic [XLEN-1:0]          instr,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    input  logic [XLEN-1:0]          result,
    output logic [XLEN-1:0]          last_result,
    output logic [$clog2(DEPTH)-1:0] pc_idx,
    output logic                     busy,
    output logic                     done,
    output logic [15:0]              issued_cnt
`ifdef INSTR_SEQUENCER_CHECK_EN
    ,
    input  logic                     exp_we,
    input  logic [XLEN-1:0]          exp_data,
    output logic                     mismatch,
    output logic [$clog2(DEPTH)-1:0] err_idx
`endif
);

    import instr_seq_pkg::*;

    localparam int AW  = $clog2(DEPTH);
    localparam int LW  = AW + 1;
    localparam int HCW = $clog2(HOLD_CYCLES + 1);
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    seq_state_t      state;
    seq_state_t      state_nxt;
    logic [LW-1:0]   len;
    logic            loop;
    logic [HCW-1:0]  hold_cnt;
    logic [XLEN-1:0] prog_rdata;
    logic            idle;
    logic            accept;
    logic            hold_last;
    logic            last_idx;
    logic            capture;

    assign idle      = (state == IDLE);
    assign accept    = idle && start && !abort;
    assign hold_last = (state == HOLD) && (hold_cnt == HCW'(1));
    assign last_idx  = ({1'b0, pc_idx} == (len - LW'(1)));
    assign capture   = hold_last && !abort;

    seq_prog_mem #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_prog_mem (
        .clk   (clk),
        .we    (load_we && idle),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (pc_idx),
        .rdata (prog_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state_nxt = (prog_len == '0) ? DONE : ISSUE;
                    end
                end
                ISSUE: begin
                    if (instr_ready) begin
                        state_nxt = HOLD;
                    end
                end
                HOLD: begin
                    if (hold_last) begin
                        state_nxt = (last_idx && !loop) ? DONE : ISSUE;
                    end
                end
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        instr       = NOP_INSTR;
        instr_valid = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        unique case (state)
            IDLE:  busy = 1'b0;
            ISSUE: begin
                instr       = prog_rdata;
                instr_valid = 1'b1;
            end
            HOLD:    instr = prog_rdata;
            DONE:    done  = 1'b1;
            default: busy  = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_idx      <= '0;
            issued_cnt  <= '0;
            last_result <= '0;
            len         <= '0;
            loop        <= 1'b0;
            hold_cnt    <= '0;
        end else if (!abort) begin
            unique case (state)
                IDLE: begin
                    if (start && (prog_len != '0)) begin
                        len        <= (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
                        loop       <= loop_en;
                        issued_cnt <= '0;
                        pc_idx     <= '0;
                    end
                end
                ISSUE: begin
                    if (instr_ready) begin
                        if (issued_cnt != '1) begin
                            issued_cnt <= issued_cnt + 16'd1;
                        end
                        hold_cnt <= HCW'(HOLD_CYCLES);
                    end
                end
                HOLD: begin
                    hold_cnt <= hold_cnt - HCW'(1);
                    if (hold_last) begin
                        last_result <= result;
                        if (!last_idx) begin
                            pc_idx <= pc_idx + AW'(1);
                        end else if (loop) begin
                            pc_idx <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef INSTR_SEQUENCER_CHECK_EN
    logic [XLEN-1:0] exp_rdata;

    seq_prog_mem #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_exp_mem (
        .clk   (clk),
        .we    (exp_we && idle),
        .waddr (load_addr),
        .wdata (exp_data),
        .raddr (pc_idx),
        .rdata (exp_rdata)
    );

    // err_idx latches only the first mismatching index of a run.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mismatch <= 1'b0;
            err_idx  <= '0;
        end else if (accept) begin
            mismatch <= 1'b0;
            err_idx  <= '0;
        end else if (capture && (result != exp_rdata)) begin
            mismatch <= 1'b1;
            if (!mismatch) begin
                err_idx <= pc_idx;
            end
        end
    end
`endif

endmodule
